md_unit: RTL
============

Name: md_unit

Overview:
- Multiply/divide unit for the EX stage of the 5-stage pipeline.
- Accepts forwarded rs/rt operands from EX together with a one-cycle start command.
- Runs a fixed-latency multi-cycle operation and owns the HI/LO architectural registers.
- HI/LO are read combinationally by mfhi/mflo in EX and travel down the E/M pipeline like an ALU result; busy feeds the hazard unit for stalling.

Parameters:
MULT_CYCLES  5   busy duration of mult/multu, in cycles (>=1)
DIV_CYCLES   10  busy duration of div/divu, in cycles (>=1)

Ports:
clk    input   1   clock; all state updates on rising edge
reset  input   1   synchronous, active-high reset
start  input   1   command valid this cycle (instr in EX is mult/multu/div/divu/mthi/mtlo and not a bubble)
md_op  input   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
a      input   32  forwarded rs value
b      input   32  forwarded rt value
busy   output  1   operation in progress
hi     output  32  HI register
lo     output  32  LO register

Behaviour:
- Reset state: busy=0, hi=0, lo=0, counter=0, pending result cleared. Reset takes priority over every other event.
- Command acceptance:
  - A command is accepted at a rising edge when start=1, busy=0 and md_op is in 1..6.
  - If start=1 while busy=1, the command is dropped and state is unchanged; the hazard unit guarantees this never happens legally.
- mthi/mtlo:
  - On accept, hi<=a (mthi) or lo<=a (mtlo) at that edge; visible the next cycle.
  - busy stays 0.
- mult/multu/div/divu on accept:
  - The 64-bit result is computed from a and b at the accepting edge and stored in internal pending_hi/pending_lo.
  - counter<=MULT_CYCLES or DIV_CYCLES; busy<=1.
- Countdown:
  - Each subsequent edge with counter>1: counter decrements.
  - Edge with counter==1: hi<=pending_hi, lo<=pending_lo (unless the div-by-zero flag is set), busy<=0, counter<=0.
  - busy is therefore high for exactly N cycles. The new hi/lo is visible in the cycle busy first reads 0.
  - hi/lo hold their old values throughout busy.
- Arithmetic:
  - mult: signed 32x32 to 64 bits; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 to 64 bits.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (32-bit wrap).
  - divu: unsigned quotient in lo, remainder in hi.
  - b==0 for div/divu: busy still runs DIV_CYCLES cycles, and hi/lo are left unchanged at completion.
- Back-to-back commands: a new command may be accepted at the same edge busy falls only if start is sampled with busy=0. Since busy is registered, the earliest new accept is the edge after busy drops.
- Outputs hi, lo and busy are all register outputs; there are no combinational paths from inputs.
- Reset mid-operation: busy=0, hi=lo=0 at the reset edge. The pending result is discarded and no late write-back occurs.
- Pipeline flush is not handled here: the issuing stage must drive start=0 for bubbles.

Test Plan:
1. mult a=0xFFFFFFFE, b=3 -> busy=1 for exactly 5 cycles, hi/lo unchanged meanwhile; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. multu a=0xFFFFFFFE, b=3 -> after 5 busy cycles hi=0x00000002, lo=0xFFFFFFFA.
3. div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. mthi a=0x12345678, then mtlo a=0x9ABCDEF0 -> hi=0x12345678 after the first edge, lo=0x9ABCDEF0 after the second, busy never set. Then divu 7/0 -> busy 10 cycles, hi/lo remain 0x12345678/0x9ABCDEF0.
5. Issue mult 6x7, then start mtlo a=0xDEAD on busy cycle 2 -> mtlo is dropped; after completion lo=42, hi=0.
6. Preload hi=lo=0x11111111, start div 100/3, assert reset on busy cycle 3 -> next cycle busy=0, hi=lo=0; no write of 33/1 occurs in the following 10 cycles.

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - EX-stage multiply/divide unit owning the HI/LO registers.
// Fixed-latency: result is computed at accept, held pending, and written back when the countdown ends.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;

  logic        accept;
  logic        is_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, div_q, div_r;

  // Division works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
  always_comb begin
    is_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
    mul_a     = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    mul_b     = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod      = mul_a * mul_b;

    a_neg = is_signed && a[31];
    b_neg = is_signed && b[31];
    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;
    if (b_mag == 32'd0) begin
      q_mag = 32'd0;
      r_mag = 32'd0;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    div_q = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    div_r = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    accept    = start && !busy_q && (md_op != 3'd0) && (md_op != 3'd7);

    if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (!pend_dz_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (accept) begin
      case (md_op)
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        OP_MULT, OP_MULTU: begin
          pend_hi_d = prod[63:32];
          pend_lo_d = prod[31:0];
          pend_dz_d = 1'b0;
          cnt_d     = CNT_W'(MULT_CYCLES);
          busy_d    = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          pend_hi_d = div_r;
          pend_lo_d = div_q;
          pend_dz_d = (b == 32'd0);
          cnt_d     = CNT_W'(DIV_CYCLES);
          busy_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
